// File: rtl/vector_mem_sequencer.sv
// Command sequencer for the 256-column memory vector: expands write/read/clear/fill
// commands into registered memory strobes and returns read data on a response port.
module vector_mem_sequencer #(
  parameter int READ_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_col,
  input  logic [2:0] cmd_row,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_col,
  output logic       busy,
  output logic       mem_en,
  output logic [7:0] mem_datain,
  output logic [7:0] mem_rwl,
  output logic [7:0] mem_wwl,
  output logic [7:0] mem_col,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_clr,
  input  logic [7:0] mem_dataout
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid may drop without a transfer, and cmd_ready is high only while idle.

  typedef enum logic [2:0] {IDLE, WR, RCLR, RD, RSP, CLR, FILL} state_t;

  localparam logic [3:0] RD_LAST = 4'(READ_WAIT);

  state_t     state;
  logic [7:0] col_q;
  logic [7:0] data_q;
  logic [2:0] row_q;
  logic [3:0] rd_cnt;
  logic [7:0] fill_cnt;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      col_q      <= 8'h00;
      data_q     <= 8'h00;
      row_q      <= 3'd0;
      rd_cnt     <= 4'd0;
      fill_cnt   <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_col    <= 8'h00;
      mem_en     <= 1'b0;
      mem_datain <= 8'h00;
      mem_rwl    <= 8'h00;
      mem_wwl    <= 8'h00;
      mem_col    <= 8'h00;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_clr    <= 1'b0;
    end else begin
      // Strobes describe the state being entered; anything not re-asserted drops to 0.
      mem_en     <= 1'b0;
      mem_datain <= 8'h00;
      mem_rwl    <= 8'h00;
      mem_wwl    <= 8'h00;
      mem_col    <= 8'h00;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_clr    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            col_q  <= cmd_col;
            row_q  <= cmd_row;
            data_q <= cmd_data;
            case (cmd_op)
              2'b00: begin
                state      <= WR;
                mem_en     <= 1'b1;
                mem_write  <= 1'b1;
                mem_wwl    <= 8'd1 << cmd_row;
                mem_col    <= cmd_col;
                mem_datain <= cmd_data;
              end
              2'b01: begin
                state   <= RCLR;
                mem_clr <= 1'b1;
              end
              2'b10: begin
                state   <= CLR;
                mem_clr <= 1'b1;
              end
              default: begin
                state      <= FILL;
                fill_cnt   <= 8'h00;
                mem_en     <= 1'b1;
                mem_write  <= 1'b1;
                mem_wwl    <= 8'd1 << cmd_row;
                mem_col    <= 8'h00;
                mem_datain <= cmd_data;
              end
            endcase
          end
        end
        WR, CLR: state <= IDLE;
        RCLR: begin
          state    <= RD;
          rd_cnt   <= 4'd1;
          mem_en   <= 1'b1;
          mem_read <= 1'b1;
          mem_rwl  <= 8'd1 << row_q;
          mem_col  <= col_q;
        end
        RD: begin
          if (rd_cnt == RD_LAST) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_data  <= mem_dataout;
            rsp_col   <= col_q;
          end else begin
            rd_cnt   <= rd_cnt + 4'd1;
            mem_en   <= 1'b1;
            mem_read <= 1'b1;
            mem_rwl  <= 8'd1 << row_q;
            mem_col  <= col_q;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        FILL: begin
          // The counter wraps to 0 on the exit edge; it only restarts on the next fill.
          fill_cnt <= fill_cnt + 8'd1;
          if (fill_cnt == 8'hFF) begin
            state <= IDLE;
          end else begin
            mem_en     <= 1'b1;
            mem_write  <= 1'b1;
            mem_wwl    <= 8'd1 << row_q;
            mem_col    <= fill_cnt + 8'd1;
            mem_datain <= data_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Bench for vector_mem_sequencer: a memory-vector model answers reads, a command-level
// reference memory predicts read data, and each command's strobe trace is checked per cycle.
module tb_vector_mem_sequencer;

  localparam int RW = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_col;
  logic [2:0] cmd_row;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] rsp_col;
  logic       busy;
  logic       mem_en;
  logic [7:0] mem_datain;
  logic [7:0] mem_rwl;
  logic [7:0] mem_wwl;
  logic [7:0] mem_col;
  logic       mem_read;
  logic       mem_write;
  logic       mem_clr;
  logic [7:0] mem_dataout;

  int n_cmp = 0;
  int n_err = 0;

  bit [7:0] phys_mem [8][256];
  bit [7:0] ref_mem [8][256];

  typedef struct {
    logic [1:0] op;
    logic [7:0] col;
    logic [2:0] row;
    logic [7:0] data;
    int         hold;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [13];

  vector_mem_sequencer #(.READ_WAIT(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_col(rsp_col),
    .busy(busy), .mem_en(mem_en), .mem_datain(mem_datain), .mem_rwl(mem_rwl),
    .mem_wwl(mem_wwl), .mem_col(mem_col), .mem_read(mem_read), .mem_write(mem_write),
    .mem_clr(mem_clr), .mem_dataout(mem_dataout)
  );

  // ---------------- clock / memory vector model ----------------
  always #5 clk = ~clk;

  function automatic logic [2:0] oh2i(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  assign mem_dataout = (mem_en && mem_read) ? phys_mem[oh2i(mem_rwl)][mem_col] : 8'h00;

  always @(posedge clk) begin
    if (mem_en && mem_write) phys_mem[oh2i(mem_wwl)][mem_col] <= mem_datain;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [36:0] sv(input logic en, input logic [7:0] din, input logic [7:0] rwl,
                                     input logic [7:0] wwl, input logic [7:0] col,
                                     input logic rd, input logic wr, input logic clr);
    return {en, din, rwl, wwl, col, rd, wr, clr};
  endfunction

  function automatic logic [36:0] act_vec();
    return {mem_en, mem_datain, mem_rwl, mem_wwl, mem_col, mem_read, mem_write, mem_clr};
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      if ((mem_read && mem_write) || (|mem_rwl && |mem_wwl)) begin
        n_err++;
        $display("FAIL exclusivity: read=%b write=%b rwl=%h wwl=%h", mem_read, mem_write, mem_rwl, mem_wwl);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns #1 after the acceptance edge T0.
  task automatic issue(input logic [1:0] op, input logic [7:0] col, input logic [2:0] row,
                       input logic [7:0] data);
    int waited;
    cmd_op = op; cmd_col = col; cmd_row = row; cmd_data = data;
    cmd_valid = 1'b1;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready !== 1'b1) chk("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = $urandom_range(0, 3); cmd_col = $urandom; cmd_row = $urandom; cmd_data = $urandom;
  endtask

  task automatic idle_check(input string name);
    chk({name, "_idle_strobes"}, act_vec(), 37'd0);
    chk({name, "_ready_back"}, {63'd0, cmd_ready}, 64'd1);
    chk({name, "_busy_low"}, {63'd0, busy}, 64'd0);
  endtask

  // Follows one accepted command cycle-by-cycle; leaves off at a negedge.
  task automatic follow(input logic [1:0] op, input logic [7:0] col, input logic [2:0] row,
                        input logic [7:0] data, input int hold, input logic [7:0] exp_rd);
    logic [7:0] oh;
    oh = 8'd1 << row;
    case (op)
      2'b00: begin
        @(negedge clk);
        chk("wr_strobe", act_vec(), sv(1'b1, data, 8'h00, oh, col, 1'b0, 1'b1, 1'b0));
        ref_mem[row][col] = data;
        @(negedge clk);
        idle_check("wr");
      end
      2'b10: begin
        @(negedge clk);
        chk("clr_strobe", act_vec(), sv(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        idle_check("clr");
      end
      2'b11: begin
        for (int c = 0; c < 256; c++) begin
          @(negedge clk);
          chk("fill_strobe", act_vec(), sv(1'b1, data, 8'h00, oh, 8'(c), 1'b0, 1'b1, 1'b0));
          ref_mem[row][c] = data;
        end
        @(negedge clk);
        idle_check("fill");
      end
      default: begin
        @(negedge clk);
        chk("rd_clr_strobe", act_vec(), sv(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < RW; i++) begin
          @(negedge clk);
          chk("rd_strobe", act_vec(), sv(1'b1, 8'h00, oh, 8'h00, col, 1'b1, 1'b0, 1'b0));
          chk("rd_no_rsp_yet", {63'd0, rsp_valid}, 64'd0);
        end
        @(negedge clk);
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_data", {56'd0, rsp_data}, {56'd0, exp_rd});
        chk("rsp_col", {56'd0, rsp_col}, {56'd0, col});
        chk("rsp_strobes_off", act_vec(), 37'd0);
        chk("rsp_not_ready", {63'd0, cmd_ready}, 64'd0);
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          chk("rsp_hold", {47'd0, rsp_valid, rsp_data, rsp_col, cmd_ready},
              {47'd0, 1'b1, exp_rd, col, 1'b0});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_retired", {63'd0, rsp_valid}, 64'd0);
        chk("rd_ready_back", {63'd0, cmd_ready}, 64'd1);
      end
    endcase
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [1:0] op;
    logic [7:0] col;
    logic [2:0] row;
    logic [7:0] data;
    int         r;

    tbl[0]  = '{2'b00, 8'h5A, 3'd3, 8'hC3, 0,  8'h00};
    tbl[1]  = '{2'b01, 8'h5A, 3'd3, 8'h00, 0,  8'hC3};
    tbl[2]  = '{2'b01, 8'h5A, 3'd3, 8'h00, 10, 8'hC3};
    tbl[3]  = '{2'b10, 8'h00, 3'd0, 8'h00, 0,  8'h00};
    tbl[4]  = '{2'b00, 8'h00, 3'd0, 8'h11, 0,  8'h00};
    tbl[5]  = '{2'b01, 8'h00, 3'd0, 8'h00, 2,  8'h11};
    tbl[6]  = '{2'b00, 8'hFF, 3'd7, 8'h3C, 0,  8'h00};
    tbl[7]  = '{2'b01, 8'hFF, 3'd7, 8'h00, 0,  8'h3C};
    tbl[8]  = '{2'b11, 8'h00, 3'd7, 8'hFF, 0,  8'h00};
    tbl[9]  = '{2'b01, 8'h00, 3'd7, 8'h00, 1,  8'hFF};
    tbl[10] = '{2'b01, 8'h80, 3'd7, 8'h00, 0,  8'hFF};
    tbl[11] = '{2'b01, 8'hFF, 3'd7, 8'h00, 3,  8'hFF};
    tbl[12] = '{2'b01, 8'h5A, 3'd3, 8'h00, 0,  8'hC3};

    // Reset held with a read pending on the command port.
    rst_n = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_col = 8'h10; cmd_row = 3'd0; cmd_data = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("reset_strobes", act_vec(), 37'd0);
      chk("reset_rsp", {47'd0, rsp_valid, rsp_data, rsp_col}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    follow(2'b01, 8'h10, 3'd0, 8'h00, 0, 8'h00);

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].op, tbl[i].col, tbl[i].row, tbl[i].data);
      follow(tbl[i].op, tbl[i].col, tbl[i].row, tbl[i].data, tbl[i].hold, tbl[i].exp_rd);
    end

    // Fill aborted by reset while column 100 is being written.
    issue(2'b11, 8'h00, 3'd2, 8'hA5);
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      chk("abort_fill_col", {56'd0, mem_col}, 64'(c));
      if (c == 100) rst_n = 1'b0;
    end
    @(negedge clk);
    chk("abort_write_low", {63'd0, mem_write}, 64'd0);
    chk("abort_busy_low", {63'd0, busy}, 64'd0);
    chk("abort_strobes", act_vec(), 37'd0);
    rst_n = 1'b1;
    for (int c = 0; c <= 100; c++) ref_mem[2][c] = 8'hA5;
    issue(2'b01, 8'd101, 3'd2, 8'h00);
    follow(2'b01, 8'd101, 3'd2, 8'h00, 0, 8'h00);
    issue(2'b01, 8'd100, 3'd2, 8'h00);
    follow(2'b01, 8'd100, 3'd2, 8'h00, 0, 8'hA5);

    // Randomized traffic against the command-level reference memory.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 40) ? 2'b00 : (r < 85) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
      col = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      row = 3'($urandom);
      data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        // A command that is withdrawn before any edge must have no effect.
        cmd_valid = 1'b1; cmd_op = 2'b00;
        #2;
        cmd_valid = 1'b0;
      end
      issue(op, col, row, data);
      follow(op, col, row, data, $urandom_range(0, 3), ref_mem[row][col]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Command sequencer directly upstream of the 256-column memory vector (8-row word lines, 8-bit data, column decoder). Accepts write, read, clear and row-fill commands over a valid/ready port. Expands each command into the cycle-accurate En/DataIn/RWL/WWL/Col_ADDRS/READ/Write/Clr strobes the memory vector needs. Captures DataOut for reads and returns it on a valid/ready response port.

## Interface
Parameters:
- READ_WAIT, 1, number of cycles READ is held before DataOut is sampled (legal values 1–15)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts command this cycle
- cmd_op  in  2  00 write, 01 read, 10 clear outputs, 11 row fill
- cmd_col  in  8  column address (ignored for clear/fill)
- cmd_row  in  3  word-line index 0–7
- cmd_data  in  8  write/fill data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes response
- rsp_data  out  8  captured read data
- rsp_col  out  8  column the data came from
- busy  out  1  high whenever state is not IDLE
- mem_en  out  1  to En
- mem_datain  out  8  to DataIn
- mem_rwl  out  8  to RWL, one-hot
- mem_wwl  out  8  to WWL, one-hot
- mem_col  out  8  to Col_ADDRS
- mem_read  out  1  to READ
- mem_write  out  1  to Write
- mem_clr  out  1  to Clr
- mem_dataout  in  8  from DataOut

## Operation
- States: IDLE, WR, RCLR, RD, RSP, CLR, FILL.
- All mem_* outputs are registered. In IDLE and RSP they are all 0.
- cmd_ready = 1 only in IDLE. A command is accepted on an edge where cmd_valid & cmd_ready.
- Command fields are latched into internal registers at acceptance. The input pins are not sampled again until the next acceptance.
- Write (00): IDLE→WR for 1 cycle.
  - mem_en=1, mem_write=1, mem_wwl=1<<row, mem_col=col, mem_datain=data.
  - Then WR→IDLE.
- Read (01): IDLE→RCLR for 1 cycle with mem_clr=1, so output cells are cleared before every read.
  - RCLR→RD for READ_WAIT cycles with mem_en=1, mem_read=1, mem_rwl=1<<row, mem_col=col.
  - mem_dataout is captured into rsp_data on the edge that ends the last RD cycle.
  - RD→RSP. In RSP, rsp_valid=1, and rsp_data/rsp_col stay stable until rsp_ready.
  - On the edge where rsp_ready=1 in RSP, go RSP→IDLE.
- Clear (10): IDLE→CLR for 1 cycle with mem_clr=1, then IDLE.
- Fill (11): IDLE→FILL for exactly 256 cycles.
  - Each cycle is a write to row `row` with data `data`.
  - mem_col counts 0,1,…,255 using an 8-bit counter.
  - The cycle with col=255 is the last; exit to IDLE on the following edge. The counter wraps to 0 and is not reused.
- mem_wwl and mem_rwl are never both nonzero. mem_read and mem_write are never both 1.
- busy = (state != IDLE).

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE, all mem_* = 0, rsp_valid=0, rsp_data=0, rsp_col=0, fill counter=0.
  - cmd_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation (WR/RD/FILL/RSP) aborts immediately:
  - The next cycle shows reset values.
  - No partial response is issued.
  - A pending rsp_valid is dropped.
- Latencies from the acceptance edge T0:
  - Write strobe in cycle T0+1; cmd_ready again at T0+2. Throughput is 1 write per 2 cycles.
  - Read: clr at T0+1, READ over T0+2…T0+1+READ_WAIT, rsp_valid from T0+2+READ_WAIT.
  - Clear: strobe at T0+1; ready at T0+2.
  - Fill: strobes T0+1…T0+256; ready at T0+257.
- Back-pressure: while rsp_valid=1 and rsp_ready=0, the block stays in RSP indefinitely and cmd_ready=0.
- rsp_valid=1 and rsp_ready=1 in the same cycle: response retires on that edge and cmd_ready=1 next cycle. There is no same-cycle command accept.
- cmd_valid may drop without acceptance; there is no requirement to hold.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with cmd_valid=1, op=01 → all mem_* =0, rsp_valid=0, busy=0. First accept occurs on the first edge with rst_n=1.
- Write col=0x5A, row=3, data=0xC3 → exactly one cycle with mem_write=1, mem_wwl=0x08, mem_col=0x5A, mem_datain=0xC3, mem_en=1. cmd_ready returns 2 cycles after accept.
- Read col=0x5A, row=3, READ_WAIT=1, memory model returns 0xC3 → mem_clr pulse, then one cycle with mem_read=1, mem_rwl=0x08. rsp_valid at T0+3 with rsp_data=0xC3, rsp_col=0x5A.
- Read with rsp_ready held low for 10 cycles → rsp_data stable, cmd_ready=0 throughout. Retire on the first rsp_ready=1 edge.
- Fill row=7, data=0xFF → 256 consecutive write cycles, mem_col 0→255 with no gaps or repeats, mem_wwl=0x80. busy drops at T0+257. Reading columns 0, 128 and 255 afterwards returns 0xFF.
- Assert rst_n=0 at fill column 100 → the next cycle has mem_write=0 and busy=0. A subsequent read of column 101 shows that it was not written.
